fp64_recip_refine: RTL and testbench

FP64_RECIP_REFINE -- requirements
Module: fp64_recip_refine

---
 rtl/fp64_recip_refine.sv | 213 +++++++++++++++++++++
 tb/tb_fp64_recip_refine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fp64_recip_refine.sv
// Newton-Raphson refinement of an fp64 reciprocal seed: Y <- Y*(2 - x*Y), ITER times,
// on one shared 64x64 multiplier, with special-operand bypass and flush-to-zero packing.
module fp64_recip_refine #(
  parameter int ITER = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x_in,
  input  logic [63:0] y0_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] fp_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MUL_A  = 3'd2,
    MUL_B  = 3'd3,
    PACK   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [63:0]        r_x;
  logic [63:0]        r_y0;
  logic [52:0]        r_mx;
  logic signed [12:0] r_ex;
  logic [63:0]        r_m;
  logic signed [12:0] r_ey;
  logic [63:0]        r_t;
  logic [2:0]         r_iter;
  logic               r_out_valid;
  logic [63:0]        r_fp_out;

  logic               w_special;
  logic [63:0]        w_mul_a;
  logic [63:0]        w_mul_b;
  logic [127:0]       w_prod;
  logic [64:0]        w_xy_base;
  logic signed [13:0] w_sh;
  logic signed [13:0] w_sh_neg;
  logic [67:0]        w_xy;
  logic [68:0]        w_t_full;
  logic [65:0]        w_r;
  logic [63:0]        w_m_norm;
  logic signed [12:0] w_ey_norm;
  logic [63:0]        w_pack;

  // NaN gives a fixed quiet NaN; inf and zero swap with the sign kept.
  function automatic logic [63:0] special_result(input logic [63:0] x);
    if ((x[62:52] == 11'h7FF) && (x[51:0] != 52'd0)) begin
      return 64'h7FF8_0000_0000_0001;
    end else if (x[62:52] == 11'h7FF) begin
      return {x[63], 63'd0};
    end else begin
      return {x[63], 11'h7FF, 52'd0};
    end
  endfunction

  assign w_special = (x_in[62:52] == 11'h7FF) || (x_in[62:0] == 63'd0);
  assign in_ready  = rst_n && (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign fp_out    = r_fp_out;

  // Shared multiplier: x*Y while in MUL_A, Y*T otherwise.
  assign w_mul_a = (r_state == MUL_A) ? {11'd0, r_mx} : r_m;
  assign w_mul_b = (r_state == MUL_A) ? r_m : r_t;
  assign w_prod  = w_mul_a * w_mul_b;

  // x*Y brought to Q.62 and aligned by the exponent sum; T = 2 - x*Y, clamped at zero.
  always_comb begin
    w_xy_base = 65'(w_prod >> 52);
    w_sh      = 14'(r_ex) + 14'(r_ey) - 14'sd2046;
    w_sh_neg  = -w_sh;
    w_xy      = 68'd0;
    if (w_sh >= 14'sd0) begin
      if (w_sh > 14'sd2) begin
        w_xy = {3'd0, w_xy_base} << 2;
      end else begin
        w_xy = {3'd0, w_xy_base} << w_sh[1:0];
      end
    end else begin
      if (w_sh_neg > 14'sd67) begin
        w_xy = 68'd0;
      end else begin
        w_xy = {3'd0, w_xy_base} >> w_sh_neg[6:0];
      end
    end
    w_t_full = {5'd0, 64'h8000_0000_0000_0000} - {1'b0, w_xy};
  end

  // Y*T back to Q1.62 with a single-bit renormalization toward [1,2).
  always_comb begin
    w_r = 66'(w_prod >> 62);
    if (w_r[65:63] != 3'd0) begin
      w_m_norm  = w_r[64:1];
      w_ey_norm = r_ey + 13'sd1;
    end else if (!w_r[62]) begin
      w_m_norm  = 64'(w_prod >> 61);
      w_ey_norm = r_ey - 13'sd1;
    end else begin
      w_m_norm  = w_r[63:0];
      w_ey_norm = r_ey;
    end
  end

  // Result packing with overflow to inf and underflow flushed to zero.
  always_comb begin
    if (r_ey >= 13'sd2047) begin
      w_pack = {r_x[63], 11'h7FF, 52'd0};
    end else if (r_ey <= 13'sd0) begin
      w_pack = {r_x[63], 63'd0};
    end else begin
      w_pack = {r_x[63], r_ey[10:0], r_m[61:10]};
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next = w_special ? DONE : UNPACK;
        end else begin
          w_next = IDLE;
        end
      end
      UNPACK:  w_next = MUL_A;
      MUL_A:   w_next = MUL_B;
      MUL_B: begin
        if (r_iter == 3'(ITER - 1)) begin
          w_next = PACK;
        end else begin
          w_next = MUL_A;
        end
      end
      PACK:    w_next = DONE;
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x         <= 64'd0;
      r_y0        <= 64'd0;
      r_mx        <= 53'd0;
      r_ex        <= 13'sd0;
      r_m         <= 64'd0;
      r_ey        <= 13'sd0;
      r_t         <= 64'd0;
      r_iter      <= 3'd0;
      r_out_valid <= 1'b0;
      r_fp_out    <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_iter <= 3'd0;
          if (in_valid) begin
            r_x  <= x_in;
            r_y0 <= y0_in;
          end
        end
        UNPACK: begin
          // Subnormals keep a leading 0 and take exponent 1, matching their true scale.
          r_mx   <= {(r_x[62:52] != 11'd0), r_x[51:0]};
          r_ex   <= (r_x[62:52] == 11'd0) ? 13'sd1 : signed'({2'b00, r_x[62:52]});
          r_m    <= {1'b0, (r_y0[62:52] != 11'd0), r_y0[51:0], 10'd0};
          r_ey   <= (r_y0[62:52] == 11'd0) ? 13'sd1 : signed'({2'b00, r_y0[62:52]});
          r_iter <= 3'd0;
        end
        MUL_A: begin
          r_t <= w_t_full[68] ? 64'd0 : 64'(w_t_full);
        end
        MUL_B: begin
          r_m    <= w_m_norm;
          r_ey   <= w_ey_norm;
          r_iter <= r_iter + 3'd1;
        end
        default: begin
        end
      endcase
      if ((w_next == DONE) && (r_state != DONE)) begin
        r_fp_out <= (r_state == IDLE) ? special_result(x_in) : w_pack;
      end
      r_out_valid <= (w_next == DONE);
    end
  end

endmodule

// File: tb/tb_fp64_recip_refine.sv
// Directed bench for fp64_recip_refine: latency, refined values, specials,
// backpressure and mid-operation reset, all against hand-computed constants.
module tb_fp64_recip_refine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x_in;
  logic [63:0] y0_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fp_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  fp64_recip_refine #(.ITER(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y0_in     (y0_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_out    (fp_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Transfer one operand pair, then count edges until out_valid (bounded).
  task automatic run_op(input logic [63:0] x, input logic [63:0] y0, output int n);
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = x;
    y0_in    = y0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_rdy_rise"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = 64'd0; y0_in = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_fp_out", fp_out, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    run_op(64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000, lat);
    chk("two_lat", 64'(lat), 64'd6);
    chk("two_val", fp_out, 64'h3FE0_0000_0000_0000);
    chk("two_busy", {63'd0, busy}, 64'd1);
    chk("two_rdy", {63'd0, in_ready}, 64'd0);
    finish_op("two");

    run_op(64'h4008_0000_0000_0000, 64'h3FD5_5500_0000_0000, lat);
    chk("three_lat", 64'(lat), 64'd6);
    chk("three_val_ok", {63'd0, (fp_out == 64'h3FD5_5555_5555_5555) ||
                                (fp_out == 64'h3FD5_5555_5555_5554)}, 64'd1);
    finish_op("three");

    run_op(64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, lat);
    chk("nan_lat", 64'(lat), 64'd0);
    chk("nan_val", fp_out, 64'h7FF8_0000_0000_0001);
    finish_op("nan");
    run_op(64'hFFF0_0000_0000_0000, 64'h1234_5678_9ABC_DEF0, lat);
    chk("ninf_lat", 64'(lat), 64'd0);
    chk("ninf_val", fp_out, 64'h8000_0000_0000_0000);
    finish_op("ninf");
    run_op(64'h8000_0000_0000_0000, 64'h3FF0_0000_0000_0000, lat);
    chk("nzero_lat", 64'(lat), 64'd0);
    chk("nzero_val", fp_out, 64'hFFF0_0000_0000_0000);
    finish_op("nzero");

    run_op(64'h7FE0_0000_0000_0000, 64'h0010_0000_0000_0000, lat);
    chk("flush_lat", 64'(lat), 64'd6);
    chk("flush_val", fp_out, 64'h0000_0000_0000_0000);
    finish_op("flush");
    run_op(64'h0010_0000_0000_0000, 64'h7FD0_0000_0000_0000, lat);
    chk("big_lat", 64'(lat), 64'd6);
    chk("big_val", fp_out, 64'h7FD0_0000_0000_0000);
    finish_op("big");

    // Backpressure: five stalled cycles with stray in_valid pulses carrying a special x.
    run_op(64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x_in     = 64'h8000_0000_0000_0000;
      @(posedge clk);
      @(negedge clk);
      chk("bp_val", fp_out, 64'h3FE0_0000_0000_0000);
      chk("bp_ov", {63'd0, out_valid}, 64'd1);
      chk("bp_rdy", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    finish_op("bp");
    repeat (3) @(negedge clk);
    chk("bp_no_stray", {63'd0, out_valid}, 64'd0);

    // Reset while in MUL_B.
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 64'h4008_0000_0000_0000;
    y0_in    = 64'h3FD5_5500_0000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rdy_in_rst", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_ov", {63'd0, out_valid}, 64'd0);
    chk("mid_fp", fp_out, 64'd0);
    chk("mid_rdy", {63'd0, in_ready}, 64'd1);
    chk("mid_busy0", {63'd0, busy}, 64'd0);
    repeat (8) @(negedge clk);
    chk("mid_no_resid", {63'd0, out_valid}, 64'd0);

    // Reset while in DONE.
    run_op(64'h4000_0000_0000_0000, 64'h3FE0_0000_0000_0000, lat);
    chk("done_pre_ov", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("done_rst_ov", {63'd0, out_valid}, 64'd0);
    chk("done_rst_fp", fp_out, 64'd0);

    run_op(64'h0010_0000_0000_0000, 64'h7FD0_0000_0000_0000, lat);
    chk("post_lat", 64'(lat), 64'd6);
    chk("post_val", fp_out, 64'h7FD0_0000_0000_0000);
    finish_op("post");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
